// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the GPIO Avalon-MM controller: register offsets,
// bus address width and the default identification word.
package gpio_ctrl_pkg;

    localparam int ADDR_W = 3;

    typedef enum logic [ADDR_W-1:0] {
        REG_DATA      = 3'd0,
        REG_DIR       = 3'd1,
        REG_IRQ_MASK  = 3'd2,
        REG_EDGE_CAP  = 3'd3,
        REG_OUT_SET   = 3'd4,
        REG_OUT_CLR   = 3'd5,
        REG_EDGE_MODE = 3'd6,
        REG_ID        = 3'd7
    } reg_addr_e;

    localparam logic [31:0] DEFAULT_ID = 32'h4750_494F;

endpackage

// File: rtl/gpio_avalon_ctrl_if.sv
// Avalon-MM slave bus bundle for the GPIO controller.
interface gpio_avalon_ctrl_if;
    import gpio_ctrl_pkg::*;

    // Handshake: avs_read/avs_write are single-cycle strobes that are always
    // accepted on the edge where they are high (no waitrequest). Each read
    // strobe yields exactly one avs_readdatavalid pulse on the following cycle.
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// Pin input synchroniser with a one-cycle history register; produces the
// synchronised value plus per-bit rising and falling edge strobes.
module gpio_sync_edge #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] s_last,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_last = sync_q[SYNC_STAGES-1];
    assign rise   = s_last & ~prev_q;
    assign fall   = prev_q & ~s_last;

endmodule

// File: rtl/gpio_avalon_ctrl.sv
// Register-programmable GPIO bank on Avalon-MM: direction/output registers,
// tristate pin drivers, edge capture and a registered level interrupt.
module gpio_avalon_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] ID_VALUE    = DEFAULT_ID
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    gpio_avalon_ctrl_if.slave avs,
    inout  wire [WIDTH-1:0]   gpio_export,
    output logic              irq
);

    logic [WIDTH-1:0] out_q, dir_q, mask_q, cap_q, mode_q;
    logic [WIDTH-1:0] s_last, rise, fall, edge_hit, wdata, w1c_clr;
    logic [31:0]      rd_mux;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk_clk),
        .rst    (reset_reset),
        .pin_in (gpio_export),
        .s_last (s_last),
        .rise   (rise),
        .fall   (fall)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign gpio_export[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    assign wdata    = avs.avs_writedata[WIDTH-1:0];
    // Output pins never capture, so driving a pin cannot raise an interrupt.
    assign edge_hit = ~dir_q & ((mode_q & fall) | (~mode_q & rise));
    assign w1c_clr  = (avs.avs_write && avs.avs_address == REG_EDGE_CAP) ? wdata : '0;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            out_q  <= '0;
            dir_q  <= '0;
            mask_q <= '0;
            mode_q <= '0;
            cap_q  <= '0;
        end else begin
            // A new edge in the same cycle as its clear keeps the bit set.
            cap_q <= (cap_q & ~w1c_clr) | edge_hit;
            if (avs.avs_write) begin
                case (avs.avs_address)
                    REG_DATA:      out_q  <= wdata;
                    REG_DIR:       dir_q  <= wdata;
                    REG_IRQ_MASK:  mask_q <= wdata;
                    REG_OUT_SET:   out_q  <= out_q | wdata;
                    REG_OUT_CLR:   out_q  <= out_q & ~wdata;
                    REG_EDGE_MODE: mode_q <= wdata;
                    default: ;
                endcase
            end
        end
    end

    // Read mux uses pre-edge register state, so a simultaneous write is not seen.
    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            REG_DATA:      rd_mux = 32'(s_last);
            REG_DIR:       rd_mux = 32'(dir_q);
            REG_IRQ_MASK:  rd_mux = 32'(mask_q);
            REG_EDGE_CAP:  rd_mux = 32'(cap_q);
            REG_EDGE_MODE: rd_mux = 32'(mode_q);
            REG_ID:        rd_mux = ID_VALUE;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            avs.avs_readdata      <= '0;
            avs.avs_readdatavalid <= 1'b0;
            irq                   <= 1'b0;
        end else begin
            avs.avs_readdata      <= avs.avs_read ? rd_mux : '0;
            avs.avs_readdatavalid <= avs.avs_read;
            irq                   <= |(cap_q & mask_q);
        end
    end

endmodule

// File: doc/gpio_avalon_ctrl.md
# gpio_avalon_ctrl

Avalon-MM slave controller for the soft-core system's 32-bit bidirectional GPIO bank. It holds per-pin direction and output registers and synchronises the pin inputs. It detects configurable rising/falling edges on input pins and raises a level interrupt toward the CPU's interrupt input. It replaces the bare tristate GPIO export with a register-programmable, interrupt-capable peripheral on the system interconnect.

## Interface
Parameters:
- WIDTH, 32, number of GPIO pins (1..32)
- SYNC_STAGES, 2, input synchroniser depth (>= 2)
- ID_VALUE, 32'h4750_494F, constant returned by ID register

Ports:
- clk_clk  in  1  system clock; one clock domain; all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- avs_address  in  3  word address of register
- avs_read  in  1  read strobe, one cycle per access
- avs_write  in  1  write strobe, one cycle per access
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, valid with avs_readdatavalid
- avs_readdatavalid  out  1  one-cycle pulse, fixed read latency 1
- gpio_export  inout  WIDTH  pins; driven only where DIR bit = 1, else high-Z
- irq  out  1  level interrupt, registered

## Operation
Register map (word offsets); bits above WIDTH-1 read 0 and are ignored on write:
- 0 DATA: read = synchronised pin value (all pins, including outputs); write = OUT register
- 1 DIR: R/W, 1 = output
- 2 IRQ_MASK: R/W, 1 = enable
- 3 EDGE_CAP: read = captured edges; write-1-to-clear
- 4 OUT_SET: write-only, OUT |= wdata; reads 0
- 5 OUT_CLR: write-only, OUT &= ~wdata; reads 0
- 6 EDGE_MODE: R/W, 0 = rising, 1 = falling
- 7 ID: read-only ID_VALUE; writes ignored

Behaviour:
- Pin i is driven with OUT[i] when DIR[i] = 1, else 'z'.
- Synchroniser chain s[0..SYNC_STAGES-1] plus prev register of the last stage.
- edge[i] = ~DIR[i] & (EDGE_MODE[i] ? (prev & ~s_last) : (s_last & ~prev)).
- EDGE_CAP[i] sets on edge[i] and clears on a W1C write. If set and clear hit the same bit in the same cycle, set wins.
- irq register = |(EDGE_CAP & IRQ_MASK), updated every cycle.
- Read and write asserted together: write is performed and the read returns the pre-write value.
- Reset values: OUT, DIR, IRQ_MASK, EDGE_CAP, EDGE_MODE, sync chain and prev = 0. avs_readdata = 0, avs_readdatavalid = 0, irq = 0, all pins high-Z.
- Reset asserted mid-operation: all state returns to reset values on the next edge, and any pending readdatavalid is dropped.
- Changing DIR from 1 to 0 stops driving next cycle. A resulting pin transition is then subject to edge detection.

## Timing
- Write accepted on the edge where avs_write = 1; no waitrequest, so every access completes.
- Register updates are visible after that edge, and a pin drives the new value in the following cycle.
- Read: address sampled at edge N; avs_readdata/avs_readdatavalid valid for exactly one cycle after edge N.
- Back-to-back reads every cycle are supported, giving readdatavalid on consecutive cycles.
- Input latency: pin change first sampled at edge 0.
  - DATA reflects it after edge SYNC_STAGES-1.
  - EDGE_CAP bit sets after edge SYNC_STAGES.
  - irq rises after edge SYNC_STAGES+1 if masked in.
- irq falls one cycle after the W1C write or mask clear that removes the last enabled captured bit.

## Structure
- Package gpio_ctrl_pkg:
  - register offset constants (REG_DATA..REG_ID)
  - default ID_VALUE
  - a localparam for the address width
- Sub-module gpio_sync_edge:
  - synchroniser chain, prev register and per-bit edge logic (WIDTH, SYNC_STAGES parameters)
  - outputs s_last and rise/fall vectors
- Top level holds the register file, read mux/pipeline, tristate drivers and irq register.

## Test plan
- Reset then read all 8 offsets: expected 0 except ID = 32'h4750_494F, with readdatavalid exactly one cycle after each read and pins high-Z.
- Write DIR = 32'h0000_00FF, DATA = 32'hA5, OUT_SET = 32'h100, OUT_CLR = 32'h01: pins[7:0] = 8'hA4 one cycle after last write, pins[31:8] undriven, DATA read of OUT via pins[7:0] = 8'hA4.
- Input-direction pin 3 driven 0→1, IRQ_MASK = 32'h8, EDGE_MODE = 0: EDGE_CAP = 32'h8 after edge 2, irq = 1 after edge 3. W1C 32'h8 clears it, and irq drops one cycle later.
- EDGE_MODE[5] = 1, pin 5 rises then falls: only the fall captures. Same pin with DIR[5] = 1: no capture.
- Edge on pin 0 in the same cycle as W1C of bit 0: EDGE_CAP[0] remains 1 and irq stays high.
- Assert reset_reset for one cycle while irq = 1 with a read in flight: irq = 0, readdatavalid suppressed, and all registers back to reset values on the next read.
